fft_load_sequencer: RTL and testbench

Parametrised front-end for the banked FFT datapath. It accepts one sample per beat over a valid/ready stream and scatters each frame of N samples across BANKS memory banks in natural or bit-reversed order. It then sequences the compute phase by emitting a stage index and an in-stage cycle index for STAGES passes of MEM_HEIGHT cycles each. It pulses `frame_done` at the end and re-arms for the next frame. It sits between the sample source and the bank memories / butterfly core, and replaces per-bench upcounter and stage-counter logic.

---
 rtl/fft_load_sequencer.sv | 127 ++++++++++++
 tb/tb_fft_load_sequencer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fft_load_sequencer.sv
// Load/compute sequencer for the banked FFT: scatters one frame of N samples across
// BANKS memories (natural or bit-reversed order), then steps stage/cycle counters.
module fft_load_sequencer #(
  parameter int DATA_BIT   = 16,
  parameter int N          = 256,
  parameter int BANKS      = 4,
  parameter int STAGES     = 4,
  localparam int MEM_HEIGHT = N / BANKS,
  localparam int ADDR_BIT   = $clog2(MEM_HEIGHT),
  localparam int STAGE_BIT  = $clog2(STAGES + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [DATA_BIT-1:0]  in_data_i,
  input  logic                 bitrev_en_i,
  input  logic                 stall_i,
  output logic [BANKS-1:0]     wr_en_o,
  output logic [ADDR_BIT-1:0]  wr_addr_o,
  output logic [DATA_BIT-1:0]  wr_data_o,
  output logic                 stage_valid_o,
  output logic [STAGE_BIT-1:0] stage_o,
  output logic [ADDR_BIT-1:0]  cycle_o,
  output logic                 frame_done_o
);

  localparam int IDX_BIT = $clog2(N);

  typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [IDX_BIT-1:0]   idx_q, idx_d;
  logic                 mode_q, mode_d;
  logic [BANKS-1:0]     wr_en_q, wr_en_d;
  logic [ADDR_BIT-1:0]  wr_addr_q, wr_addr_d;
  logic [DATA_BIT-1:0]  wr_data_q, wr_data_d;
  logic [STAGE_BIT-1:0] stage_q, stage_d;
  logic [ADDR_BIT-1:0]  cycle_q, cycle_d;

  logic [IDX_BIT-1:0]   idx_rev;
  logic [IDX_BIT-1:0]   eff_idx;
  logic                 mode_eff;
  logic                 beat;

  assign in_ready_o    = (state_q == S_LOAD);
  assign beat          = in_valid_i & in_ready_o;
  assign stage_valid_o = (state_q == S_COMPUTE) & ~stall_i;
  assign frame_done_o  = (state_q == S_DONE);
  assign wr_en_o       = wr_en_q;
  assign wr_addr_o     = wr_addr_q;
  assign wr_data_o     = wr_data_q;
  assign stage_o       = stage_q;
  assign cycle_o       = cycle_q;

  always_comb begin
    idx_rev = '0;
    for (int b = 0; b < IDX_BIT; b++) idx_rev[b] = idx_q[IDX_BIT-1-b];
  end

  // Beat 0 has not latched the mode yet, so it follows the live select.
  assign mode_eff = (idx_q == '0) ? bitrev_en_i : mode_q;
  assign eff_idx  = mode_eff ? idx_rev : idx_q;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    mode_d    = mode_q;
    wr_en_d   = '0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    stage_d   = stage_q;
    cycle_d   = cycle_q;
    case (state_q)
      S_LOAD: begin
        if (beat) begin
          idx_d     = idx_q + 1'b1;
          if (idx_q == '0) mode_d = bitrev_en_i;
          wr_en_d   = BANKS'(1) << (eff_idx >> ADDR_BIT);
          wr_addr_d = eff_idx[ADDR_BIT-1:0];
          wr_data_d = in_data_i;
          if (idx_q == IDX_BIT'(N - 1)) state_d = S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        if (!stall_i) begin
          if (cycle_q == ADDR_BIT'(MEM_HEIGHT - 1)) begin
            cycle_d = '0;
            if (stage_q == STAGE_BIT'(STAGES - 1)) begin
              stage_d = '0;
              state_d = S_DONE;
            end else begin
              stage_d = stage_q + 1'b1;
            end
          end else begin
            cycle_d = cycle_q + 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_LOAD;
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_LOAD;
      idx_q     <= '0;
      mode_q    <= 1'b0;
      wr_en_q   <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      stage_q   <= '0;
      cycle_q   <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      mode_q    <= mode_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      stage_q   <= stage_d;
      cycle_q   <= cycle_d;
    end
  end

endmodule

// File: tb/tb_fft_load_sequencer.sv
// Directed bench for fft_load_sequencer at default parameters (N=256, BANKS=4, STAGES=4).
module tb_fft_load_sequencer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        bitrev_en;
  logic        stall;
  logic [3:0]  wr_en;
  logic [5:0]  wr_addr;
  logic [15:0] wr_data;
  logic        stage_valid;
  logic [2:0]  stage;
  logic [5:0]  cycle;
  logic        frame_done;

  int errors = 0;
  int checks = 0;

  fft_load_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid_i    (in_valid),
    .in_ready_o    (in_ready),
    .in_data_i     (in_data),
    .bitrev_en_i   (bitrev_en),
    .stall_i       (stall),
    .wr_en_o       (wr_en),
    .wr_addr_o     (wr_addr),
    .wr_data_o     (wr_data),
    .stage_valid_o (stage_valid),
    .stage_o       (stage),
    .cycle_o       (cycle),
    .frame_done_o  (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_wr_en"}, wr_en, 0);
    chk({tag, "_wr_addr"}, wr_addr, 0);
    chk({tag, "_wr_data"}, wr_data, 0);
    chk({tag, "_stage_valid"}, stage_valid, 0);
    chk({tag, "_stage"}, stage, 0);
    chk({tag, "_cycle"}, cycle, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
  endtask

  // Starts on the first compute cycle; stalls for stn cycles from compute cycle st0.
  task automatic run_compute(input string tag, input int st0, input int stn);
    int c = 0;
    for (int t = 0; t < 256 + stn; t++) begin
      stall = (t >= st0) && (t < st0 + stn);
      #1;
      chk({tag, "_stage"}, stage, c / 64);
      chk({tag, "_cycle"}, cycle, c % 64);
      chk({tag, "_stage_valid"}, stage_valid, !stall);
      chk({tag, "_in_ready"}, in_ready, 0);
      if (t == 1) chk({tag, "_wr_en_idle"}, wr_en, 0);
      tick();
      if (!stall) c++;
    end
    stall = 1'b0;
    #1;
    chk({tag, "_done"}, frame_done, 1);
    chk({tag, "_done_stage"}, stage, 0);
    chk({tag, "_done_cycle"}, cycle, 0);
    chk({tag, "_done_sv"}, stage_valid, 0);
    chk({tag, "_done_ready"}, in_ready, 0);
  endtask

  initial begin
    int nb;
    int nwr;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; bitrev_en = 1'b0; stall = 1'b0;
    tick(); tick();
    chk_reset("rst0");
    stall = 1'b1; #1;
    chk("rst0_stall_sv", stage_valid, 0);
    stall = 1'b0;
    rst = 1'b0;

    // Natural load, continuous valid, data = idx mod 32
    for (int i = 0; i < 256; i++) begin
      in_valid = 1'b1; bitrev_en = 1'b0; in_data = 16'(i % 32);
      tick();
      if (i == 0)   begin chk("nat0_en", wr_en, 4'b0001); chk("nat0_addr", wr_addr, 0); end
      if (i == 64)  begin chk("nat64_en", wr_en, 4'b0010); chk("nat64_addr", wr_addr, 0); chk("nat64_data", wr_data, 0); end
      if (i == 130) begin chk("nat130_en", wr_en, 4'b0100); chk("nat130_addr", wr_addr, 2); chk("nat130_data", wr_data, 2); end
      if (i == 254) chk("nat254_ready", in_ready, 1);
      if (i == 255) begin
        chk("nat255_en", wr_en, 4'b1000); chk("nat255_addr", wr_addr, 63); chk("nat255_data", wr_data, 31);
        chk("nat255_ready", in_ready, 0);
      end
    end
    run_compute("cmpA", 1000, 0);
    tick();
    chk("cmpA_after_ready", in_ready, 1);
    chk("cmpA_after_done", frame_done, 0);
    chk("cmpA_after_en", wr_en, 0);

    // Bit-reversed load; select toggled after beat 0 must not matter
    for (int i = 0; i < 256; i++) begin
      in_valid = 1'b1; bitrev_en = (i == 0) ? 1'b1 : 1'(i % 2); in_data = 16'(i);
      tick();
      if (i == 0) begin chk("br0_en", wr_en, 4'b0001); chk("br0_addr", wr_addr, 0); end
      if (i == 1) begin chk("br1_en", wr_en, 4'b0100); chk("br1_addr", wr_addr, 0); end
      if (i == 2) begin chk("br2_en", wr_en, 4'b0010); chk("br2_addr", wr_addr, 0); end
      if (i == 3) begin chk("br3_en", wr_en, 4'b1000); chk("br3_addr", wr_addr, 0); end
      if (i == 4) begin chk("br4_en", wr_en, 4'b0001); chk("br4_addr", wr_addr, 32); chk("br4_data", wr_data, 4); end
      if (i == 5) begin chk("br5_en", wr_en, 4'b0100); chk("br5_addr", wr_addr, 32); end
    end
    in_valid = 1'b0;
    run_compute("cmpB", 138, 5);
    tick();
    chk("cmpB_after_ready", in_ready, 1);

    // Valid every third cycle
    nb = 0; nwr = 0;
    bitrev_en = 1'b0;
    for (int cyc = 0; cyc < 800 && nb < 256; cyc++) begin
      in_valid = (cyc % 3 == 0);
      in_data = 16'(nb) ^ 16'h5A5A;
      tick();
      if (wr_en != 0) nwr++;
      if (in_valid) begin
        chk("gap_en", wr_en, 4'b0001 << (nb / 64));
        chk("gap_addr", wr_addr, nb % 64);
        chk("gap_data", wr_data, 16'(nb) ^ 16'h5A5A);
        nb++;
      end else begin
        chk("gap_idle_en", wr_en, 0);
      end
      chk("gap_ready", in_ready, nb < 256);
    end
    chk("gap_beats", nb, 256);
    chk("gap_writes", nwr, 256);
    in_valid = 1'b0;
    for (int t = 0; t < 70; t++) tick();
    chk("midc_stage", stage, 1);
    chk("midc_cycle", cycle, 6);
    rst = 1'b1; tick(); rst = 1'b0;
    chk_reset("rst_midc");

    // Partial bit-reversed load aborted by reset at beat 100
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1; bitrev_en = (i == 0); in_data = 16'h0200 + 16'(i);
      tick();
    end
    rst = 1'b1; tick(); rst = 1'b0;
    chk_reset("rst_midl");
    for (int i = 0; i < 256; i++) begin
      in_valid = 1'b1; bitrev_en = 1'b0; in_data = 16'h0100 + 16'(i);
      tick();
      if (i == 0)   begin chk("post_rst0_en", wr_en, 4'b0001); chk("post_rst0_addr", wr_addr, 0); chk("post_rst0_data", wr_data, 16'h0100); end
      if (i == 1)   begin chk("post_rst1_en", wr_en, 4'b0001); chk("post_rst1_addr", wr_addr, 1); end
      if (i == 200) begin chk("post_rst200_en", wr_en, 4'b1000); chk("post_rst200_addr", wr_addr, 8); end
    end
    run_compute("cmpC", 1000, 0);

    // Back-to-back: valid held through compute/done, next frame bit-reversed
    bitrev_en = 1'b1; in_data = 16'h0BEE;
    tick();
    chk("b2b_done_pulse", frame_done, 0);
    chk("b2b_ready", in_ready, 1);
    chk("b2b_no_beat_in_done", wr_en, 0);
    tick();
    chk("b2b0_en", wr_en, 4'b0001);
    chk("b2b0_addr", wr_addr, 0);
    chk("b2b0_data", wr_data, 16'h0BEE);
    bitrev_en = 1'b0;
    tick();
    chk("b2b1_en", wr_en, 4'b0100);
    chk("b2b1_addr", wr_addr, 0);
    in_valid = 1'b0;
    tick();
    chk("b2b_idle_en", wr_en, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
